coreid_reader: RTL and testbench
================================

// Module: coreid_reader
// PURPOSE
//  On-chip initiator for the ZX-Uno core-ID register: reads the NUL-terminated ID
//  string served at register REGADDR into a local buffer, byte by byte, with no CPU
//  involvement. Sits beside the Z80 register path, behind the host bus arbiter, and
//  feeds the OSD/boot-screen logic. bus_req is high for the whole transaction.
// PARAMETERS
//  REGADDR    8'hFF  register number of the core-ID responder
//  MAXLEN     16     buffer depth in bytes; fetch stops here even without a NUL
//  RD_CYCLES  2      width of each zxuno_regrd strobe in clk cycles (>=1)
//  GAP_CYCLES 2      idle cycles between strobes (>=2; responder index advance + dout reload)
// PORTS
//  clk              in   1  system clock
//  rst              in   1  asynchronous, active-high reset
//  start            in   1  one-cycle request to (re)fetch the ID string
//  bus_req          out  1  high while the register bus is owned (busy)
//  zxuno_addr       out  8  REGADDR while busy, 8'h00 otherwise
//  regaddr_changed  out  1  one-cycle select pulse; resets the responder's text index
//  zxuno_regrd      out  1  read strobe towards the responder
//  din              in   8  responder data, registered on the responder side
//  busy             out  1  fetch in progress
//  done             out  1  one-cycle pulse when the fetch completes
//  len              out  5  bytes captured, excluding the NUL (0..MAXLEN)
//  rd_index         in   4  buffer read address
//  rd_char          out  8  buf[rd_index] if rd_index<len, else 8'h00 (combinational)
// BEHAVIOUR
//  - Reset (async): state IDLE; bus_req=busy=done=regaddr_changed=zxuno_regrd=0;
//    zxuno_addr=8'h00; len=0; byte counter=0. Buffer contents are don't-care; rd_char masked by len.
//  - FSM: IDLE -> SELECT -> SETTLE -> STROBE -> GAP -> {STROBE | FINISH} -> IDLE.
//  - IDLE: start=1 -> SELECT next cycle; len<=0, counter<=0.
//  - SELECT (1 cyc): zxuno_addr=REGADDR, regaddr_changed=1, regrd=0.
//  - SETTLE (1 cyc): addr held, strobes low; responder dout reloads to byte 0.
//  - STROBE (RD_CYCLES cyc): zxuno_regrd=1; din sampled on the last strobe cycle only.
//    Sampled byte ==8'h00 -> FINISH, nothing stored. Otherwise buf[counter]<=din,
//    counter++ and len++ -> GAP.
//  - GAP (GAP_CYCLES cyc): regrd=0; the responder advances its index when the strobe drops.
//    Then counter==MAXLEN -> FINISH; else -> STROBE.
//  - FINISH (1 cyc): done=1, addr back to 8'h00 -> IDLE. busy/bus_req are high SELECT..FINISH inclusive.
//  - Latency for an N-char string (N<MAXLEN): 2+(N+1)*RD_CYCLES+N*GAP_CYCLES+1 cycles,
//    counted from the cycle after start up to and including the done cycle.
//  - start while busy: ignored. A new start in IDLE restarts from byte 0; len clears at once.
//  - Reset mid-operation: abort at once; outputs take reset values; no done pulse.
//  - len width 5 covers MAXLEN=16 inclusive; counter never wraps (MAXLEN check precedes increment).
// STRUCTURE
//  - Shared package zxuno_regs_pkg: REG_COREID=8'hFF, COREID_MAXLEN=16, and the
//    reader state encoding (IDLE, SELECT, SETTLE, STROBE, GAP, FINISH).
//  - One sub-module: coreid_reader_buf. MAXLENx8 register file; sync write
//    (we, waddr, wdata); async read; length masking lives in the parent.
//  - The parent holds the FSM, strobe/gap timer (width from max(RD_CYCLES,GAP_CYCLES)), counter and len.
// TESTING (bench pairs the DUT with a responder model that resets its index on select and
// advances it on strobe release)
//  1. Responder text "T22-11092016",0; pulse start -> exactly 13 strobes, one done,
//     len=12, rd_char(0)=8'h54 'T', rd_char(11)=8'h36 '6', rd_char(12)=8'h00.
//  2. Responder 16 non-NUL bytes "ABCDEFGHIJKLMNOP" -> 16 strobes, len=16, rd_char(15)=8'h50, no 17th strobe.
//  3. Responder first byte 8'h00 -> one strobe, done, len=0, every rd_char=8'h00.
//  4. Assert rst during the 5th strobe -> regrd, bus_req, busy low within the same cycle
//     (async); no done; len=0. A later start gives the full result of scenario 1.
//  5. start pulsed again at cycle 3 of a fetch -> ignored: one done only, len=12.
//     Immediate re-start after done -> identical buffer (index reset by regaddr_changed).
//  6. RD_CYCLES=1, GAP_CYCLES=2 with scenario 1 -> done exactly 2+13+24+1=40 cycles after start.

Source files
------------

// File: rtl/zxuno_regs_pkg.sv
// rtl/zxuno_regs_pkg.sv - ZX-Uno register numbers and core-ID reader state encoding
package zxuno_regs_pkg;

    localparam logic [7:0] REG_COREID    = 8'hFF;
    localparam int         COREID_MAXLEN = 16;

    typedef enum logic [2:0] {
        RD_IDLE   = 3'd0,
        RD_SELECT = 3'd1,
        RD_SETTLE = 3'd2,
        RD_STROBE = 3'd3,
        RD_GAP    = 3'd4,
        RD_FINISH = 3'd5
    } reader_state_t;

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/coreid_reader_buf.sv
// rtl/coreid_reader_buf.sv - core-ID byte buffer, synchronous write, asynchronous read
module coreid_reader_buf #(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [7:0]    wdata,
    input  logic [AW-1:0] raddr,
    output logic [7:0]    rdata
);

    logic [7:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            r_mem[waddr] <= wdata;
        end
    end

    assign rdata = r_mem[raddr];

endmodule

// File: rtl/coreid_reader.sv
// rtl/coreid_reader.sv - fetches the NUL-terminated core-ID string into a local buffer
module coreid_reader
    import zxuno_regs_pkg::*;
#(
    parameter logic [7:0] REGADDR    = REG_COREID,
    parameter int         MAXLEN     = COREID_MAXLEN,
    parameter int         RD_CYCLES  = 2,
    parameter int         GAP_CYCLES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    output logic       bus_req,
    output logic [7:0] zxuno_addr,
    output logic       regaddr_changed,
    output logic       zxuno_regrd,
    input  logic [7:0] din,
    output logic       busy,
    output logic       done,
    output logic [4:0] len,
    input  logic [3:0] rd_index,
    output logic [7:0] rd_char
);

    localparam int             TW       = $clog2(max2(RD_CYCLES, GAP_CYCLES) + 1);
    localparam logic [TW-1:0]  RD_LAST  = TW'(RD_CYCLES - 1);
    localparam logic [TW-1:0]  GAP_LAST = TW'(GAP_CYCLES - 1);
    localparam logic [4:0]     LEN_MAX  = 5'(MAXLEN);

    reader_state_t r_state;
    reader_state_t w_state_nxt;
    logic [TW-1:0] r_timer;
    logic [4:0]    r_count;
    logic [4:0]    r_len;
    logic          w_last_strobe;
    logic          w_last_gap;
    logic          w_nul;
    logic          w_store;
    logic [7:0]    w_buf_rdata;

    always_comb begin
        w_last_strobe = (r_state == RD_STROBE) && (r_timer == RD_LAST);
        w_last_gap    = (r_state == RD_GAP) && (r_timer == GAP_LAST);
        w_nul         = (din == 8'h00);
        w_store       = w_last_strobe && !w_nul;
        w_state_nxt   = r_state;
        case (r_state)
            RD_IDLE:   if (start) w_state_nxt = RD_SELECT;
            RD_SELECT: w_state_nxt = RD_SETTLE;
            RD_SETTLE: w_state_nxt = RD_STROBE;
            RD_STROBE: if (w_last_strobe) w_state_nxt = w_nul ? RD_FINISH : RD_GAP;
            RD_GAP:    if (w_last_gap) w_state_nxt = (r_count == LEN_MAX) ? RD_FINISH : RD_STROBE;
            RD_FINISH: w_state_nxt = RD_IDLE;
            default:   w_state_nxt = RD_IDLE;
        endcase
    end

    // Timer restarts on every state change; only STROBE and GAP consume it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= RD_IDLE;
            r_timer <= '0;
            r_count <= '0;
            r_len   <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (((r_state == RD_STROBE) || (r_state == RD_GAP)) && (w_state_nxt == r_state)) begin
                r_timer <= r_timer + 1'b1;
            end else begin
                r_timer <= '0;
            end
            if ((r_state == RD_IDLE) && start) begin
                r_count <= '0;
                r_len   <= '0;
            end else if (w_store) begin
                r_count <= r_count + 5'd1;
                r_len   <= r_len + 5'd1;
            end
        end
    end

    coreid_reader_buf #(
        .DEPTH (MAXLEN),
        .AW    (4)
    ) u_buf (
        .clk   (clk),
        .we    (w_store),
        .waddr (r_count[3:0]),
        .wdata (din),
        .raddr (rd_index),
        .rdata (w_buf_rdata)
    );

    // Outputs decode straight from the state register so reset drops them immediately.
    assign busy            = (r_state != RD_IDLE);
    assign bus_req         = busy;
    assign done            = (r_state == RD_FINISH);
    assign regaddr_changed = (r_state == RD_SELECT);
    assign zxuno_regrd     = (r_state == RD_STROBE);
    assign zxuno_addr      = (busy && !done) ? REGADDR : 8'h00;
    assign len             = r_len;
    assign rd_char         = ({1'b0, rd_index} < r_len) ? w_buf_rdata : 8'h00;

endmodule

// File: tb/tb_coreid_reader.sv
// tb/tb_coreid_reader.sv - randomized bench for coreid_reader with a core-ID responder model
module tb_coreid_reader;

    localparam int RD  = 2;
    localparam int GAP = 2;
    localparam int ML  = 16;
    localparam int TL  = 24;

    logic       clk = 1'b0;
    logic       rst;
    logic       start_a, start_f;
    logic       bus_req_a, bus_req_f;
    logic [7:0] addr_a, addr_f;
    logic       sel_a, sel_f;
    logic       regrd_a, regrd_f;
    logic [7:0] din_a = 8'h00, din_f = 8'h00;
    logic       busy_a, busy_f;
    logic       done_a, done_f;
    logic [4:0] len_a, len_f;
    logic [3:0] rdi_a, rdi_f;
    logic [7:0] rdc_a, rdc_f;

    logic [7:0] text [TL];
    int idx_a = 0, idx_f = 0;
    logic prev_a = 1'b0, prev_f = 1'b0;
    int n_strobe_a = 0, n_done_a = 0;
    int n_checks = 0, n_pass = 0;

    always #5 clk = ~clk;

    coreid_reader dut_a (
        .clk(clk), .rst(rst), .start(start_a), .bus_req(bus_req_a), .zxuno_addr(addr_a),
        .regaddr_changed(sel_a), .zxuno_regrd(regrd_a), .din(din_a), .busy(busy_a),
        .done(done_a), .len(len_a), .rd_index(rdi_a), .rd_char(rdc_a)
    );

    coreid_reader #(.RD_CYCLES(1), .GAP_CYCLES(2)) dut_f (
        .clk(clk), .rst(rst), .start(start_f), .bus_req(bus_req_f), .zxuno_addr(addr_f),
        .regaddr_changed(sel_f), .zxuno_regrd(regrd_f), .din(din_f), .busy(busy_f),
        .done(done_f), .len(len_f), .rd_index(rdi_f), .rd_char(rdc_f)
    );

    // Responder: index resets on select, advances when the strobe drops, output registered.
    always @(posedge clk) begin
        if (sel_a && addr_a == 8'hFF) idx_a <= 0;
        else if (prev_a && !regrd_a) idx_a <= idx_a + 1;
        prev_a <= regrd_a;
        din_a  <= (idx_a < TL) ? text[idx_a] : 8'h51;
        if (regrd_a && !prev_a) n_strobe_a <= n_strobe_a + 1;
        if (done_a) n_done_a <= n_done_a + 1;
    end

    always @(posedge clk) begin
        if (sel_f && addr_f == 8'hFF) idx_f <= 0;
        else if (prev_f && !regrd_f) idx_f <= idx_f + 1;
        prev_f <= regrd_f;
        din_f  <= (idx_f < TL) ? text[idx_f] : 8'h51;
    end

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic load_text(input string s, input bit term);
        for (int i = 0; i < TL; i++) begin
            if (i < s.len()) text[i] = s[i];
            else if (i == s.len() && term) text[i] = 8'h00;
            else text[i] = 8'h51;
        end
    endtask

    task automatic fetch_a(input string tag, input int restart_at, output int lat);
        int cyc;
        start_a = 1'b1;
        @(posedge clk); #1;
        start_a = 1'b0;
        cyc = 1;
        check({tag, ".select"}, int'(sel_a), 1);
        while (!done_a && cyc < 500) begin
            if (cyc == 2) check({tag, ".settle_addr"}, int'(addr_a), 8'hFF);
            start_a = (cyc == restart_at);
            @(posedge clk); #1;
            cyc++;
        end
        start_a = 1'b0;
        lat = cyc;
        check({tag, ".finish_addr"}, int'(addr_a), 0);
        @(posedge clk); #1;
    endtask

    task automatic expect_result(input string tag, input int lat, input int strobes, input int dones);
        int exp_len, exp_str;
        exp_len = 0;
        while (exp_len < ML && text[exp_len] != 8'h00) exp_len++;
        exp_str = (exp_len < ML) ? exp_len + 1 : ML;
        check({tag, ".len"}, int'(len_a), exp_len);
        check({tag, ".latency"}, lat, 2 + exp_str * RD + exp_len * GAP + 1);
        check({tag, ".strobes"}, strobes, exp_str);
        check({tag, ".dones"}, dones, 1);
        check({tag, ".idle"}, int'(busy_a), 0);
        for (int i = 0; i < ML; i++) begin
            @(negedge clk);
            rdi_a = 4'(i);
            #1;
            check($sformatf("%s.rd_char%0d", tag, i), int'(rdc_a), (i < exp_len) ? int'(text[i]) : 0);
        end
    endtask

    task automatic run(input string tag, input int restart_at);
        int s0, d0, lat;
        s0 = n_strobe_a;
        d0 = n_done_a;
        fetch_a(tag, restart_at, lat);
        expect_result(tag, lat, n_strobe_a - s0, n_done_a - d0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int s0, d0, cyc, lat, lat2, nl;
        rst = 1'b1; start_a = 1'b0; start_f = 1'b0; rdi_a = 4'd0; rdi_f = 4'd0;
        load_text("T22-11092016", 1'b1);
        repeat (2) @(posedge clk);
        #1;
        check("rst.busy", int'(busy_a), 0);
        check("rst.bus_req", int'(bus_req_a), 0);
        check("rst.done", int'(done_a), 0);
        check("rst.regrd", int'(regrd_a), 0);
        check("rst.sel", int'(sel_a), 0);
        check("rst.addr", int'(addr_a), 0);
        check("rst.len", int'(len_a), 0);
        check("rst.rd_char", int'(rdc_a), 0);
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;

        run("s1", 0);
        load_text("ABCDEFGHIJKLMNOP", 1'b0);
        run("s2", 0);
        load_text("", 1'b1);
        run("s3", 0);

        load_text("T22-11092016", 1'b1);
        s0 = n_strobe_a; d0 = n_done_a;
        start_a = 1'b1;
        @(posedge clk); #1;
        start_a = 1'b0;
        cyc = 0;
        while (n_strobe_a - s0 < 5 && cyc < 500) begin
            @(posedge clk); #1;
            cyc++;
        end
        check("s4.reach5", n_strobe_a - s0, 5);
        check("s4.regrd_pre", int'(regrd_a), 1);
        rst = 1'b1;
        #1;
        check("s4.regrd", int'(regrd_a), 0);
        check("s4.bus_req", int'(bus_req_a), 0);
        check("s4.busy", int'(busy_a), 0);
        check("s4.addr", int'(addr_a), 0);
        @(negedge clk); rst = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check("s4.no_done", n_done_a - d0, 0);
        check("s4.len", int'(len_a), 0);
        run("s4b", 0);

        run("s5", 3);
        fetch_a("s5a", 0, lat);
        s0 = n_strobe_a; d0 = n_done_a;
        fetch_a("s5b", 0, lat2);
        expect_result("s5b", lat2, n_strobe_a - s0, n_done_a - d0);

        for (int t = 0; t < 6; t++) begin
            nl = $urandom_range(0, 19);
            for (int i = 0; i < TL; i++) text[i] = (i == nl) ? 8'h00 : 8'($urandom_range(1, 255));
            run($sformatf("rnd%0d", t), (t % 2 == 1) ? int'($urandom_range(2, 20)) : 0);
        end

        load_text("T22-11092016", 1'b1);
        @(negedge clk);
        start_f = 1'b1;
        @(posedge clk); #1;
        start_f = 1'b0;
        cyc = 1;
        while (!done_f && cyc < 500) begin
            @(posedge clk); #1;
            cyc++;
        end
        check("s6.latency", cyc, 2 + 13 * 1 + 12 * 2 + 1);
        @(posedge clk); #1;
        check("s6.len", int'(len_f), 12);
        rdi_f = 4'd0; #1;
        check("s6.rd_char0", int'(rdc_f), 8'h54);
        rdi_f = 4'd11; #1;
        check("s6.rd_char11", int'(rdc_f), 8'h36);
        rdi_f = 4'd12; #1;
        check("s6.rd_char12", int'(rdc_f), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
